// File: rtl/llpm_select_rr_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | llpm_select_rr_if : valid/bp bundle for the N:1 round-robin select.      |
// | x_last/a_last exist only when LLPM_SELECT_RR_LOCK_EN is defined.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface llpm_select_rr_if #(
  parameter int WIDTH            = 8,
  parameter int NUM_INPUTS       = 4,
  parameter int CLOG2_NUM_INPUTS = 2
);
  logic [NUM_INPUTS*WIDTH-1:0] x;
  logic [NUM_INPUTS-1:0]       x_valid;
  logic [NUM_INPUTS-1:0]       x_bp;
  logic [WIDTH-1:0]            a;
  logic                        a_valid;
  logic                        a_bp;
  logic [CLOG2_NUM_INPUTS-1:0] a_sel;
`ifdef LLPM_SELECT_RR_LOCK_EN
  logic [NUM_INPUTS-1:0]       x_last;
  logic                        a_last;

  modport master (output x, x_valid, x_last, a_bp,
                  input  x_bp, a, a_valid, a_sel, a_last);
  modport slave  (input  x, x_valid, x_last, a_bp,
                  output x_bp, a, a_valid, a_sel, a_last);
`else
  modport master (output x, x_valid, a_bp,
                  input  x_bp, a, a_valid, a_sel);
  modport slave  (input  x, x_valid, a_bp,
                  output x_bp, a, a_valid, a_sel);
`endif
endinterface
`default_nettype wire

// File: rtl/llpm_select_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | llpm_select_rr : fair N:1 round-robin select, one-entry registered slot. |
// | Packet locking enabled by defining LLPM_SELECT_RR_LOCK_EN.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module llpm_select_rr #(
  parameter int WIDTH            = 8,
  parameter int NUM_INPUTS       = 4,
  parameter int CLOG2_NUM_INPUTS = 2
) (
  input  wire logic       clk,
  input  wire logic       reset,
  llpm_select_rr_if.slave bus
);

  logic [WIDTH-1:0]            r_a;
  logic                        r_a_valid;
  logic [CLOG2_NUM_INPUTS-1:0] r_a_sel;
  logic [CLOG2_NUM_INPUTS-1:0] r_last_grant;

  logic [NUM_INPUTS-1:0]       w_req;
  logic [NUM_INPUTS-1:0]       w_rot;
  logic [NUM_INPUTS-1:0]       w_x_bp;
  logic                        w_load;
  logic                        w_has_valid;
  logic [CLOG2_NUM_INPUTS-1:0] w_grant;
  logic [WIDTH-1:0]            w_sel_data;

`ifdef LLPM_SELECT_RR_LOCK_EN
  logic                        r_a_last;
  logic                        r_locked;
  logic [CLOG2_NUM_INPUTS-1:0] r_lock_ch;
  logic                        w_sel_last;
`endif

  assign w_load = ~r_a_valid | ~bus.a_bp;

  always_comb begin : p_req
    w_req = bus.x_valid;
`ifdef LLPM_SELECT_RR_LOCK_EN
    // A locked message masks every other requester, even while its own valid is low.
    if (r_locked) begin
      w_req            = '0;
      w_req[r_lock_ch] = bus.x_valid[r_lock_ch];
    end
`endif
  end

  // Rotate so bit 0 is the channel after last_grant; the first set bit wins.
  always_comb begin : p_arb
    int idx;
    w_rot       = NUM_INPUTS'({w_req, w_req} >> (int'(r_last_grant) + 1));
    w_has_valid = 1'b0;
    w_grant     = '0;
    idx         = 0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      if (!w_has_valid && w_rot[j]) begin
        w_has_valid = 1'b1;
        idx         = int'(r_last_grant) + 1 + j;
        if (idx >= NUM_INPUTS) begin
          idx = idx - NUM_INPUTS;
        end
        w_grant = CLOG2_NUM_INPUTS'(idx);
      end
    end
  end

  always_comb begin : p_mux
    w_sel_data = '0;
    w_x_bp     = '1;
`ifdef LLPM_SELECT_RR_LOCK_EN
    w_sel_last = 1'b0;
`endif
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (w_grant == CLOG2_NUM_INPUTS'(i)) begin
        w_sel_data = bus.x[i*WIDTH +: WIDTH];
`ifdef LLPM_SELECT_RR_LOCK_EN
        w_sel_last = bus.x_last[i];
`endif
        w_x_bp[i]  = ~(w_load & w_has_valid & ~reset);
      end
    end
  end

  always_ff @(posedge clk) begin : p_slot
    if (reset) begin
      r_a          <= '0;
      r_a_valid    <= 1'b0;
      r_a_sel      <= '0;
      r_last_grant <= CLOG2_NUM_INPUTS'(NUM_INPUTS - 1);
`ifdef LLPM_SELECT_RR_LOCK_EN
      r_a_last     <= 1'b0;
      r_locked     <= 1'b0;
      r_lock_ch    <= '0;
`endif
    end else if (w_load) begin
      if (w_has_valid) begin
        r_a          <= w_sel_data;
        r_a_sel      <= w_grant;
        r_a_valid    <= 1'b1;
        r_last_grant <= w_grant;
`ifdef LLPM_SELECT_RR_LOCK_EN
        r_a_last     <= w_sel_last;
        r_locked     <= ~w_sel_last;
        r_lock_ch    <= w_grant;
`endif
      end else begin
        r_a_valid <= 1'b0;
      end
    end
  end

  assign bus.x_bp    = w_x_bp;
  assign bus.a       = r_a;
  assign bus.a_valid = r_a_valid;
  assign bus.a_sel   = r_a_sel;
`ifdef LLPM_SELECT_RR_LOCK_EN
  assign bus.a_last  = r_a_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_llpm_select_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_llpm_select_rr : vector tables, corner sequences and randomized run   |
// | against a reference model, on a 4-input and a 3-input instance.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_llpm_select_rr;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  llpm_select_rr_if #(.WIDTH(8), .NUM_INPUTS(4), .CLOG2_NUM_INPUTS(2)) bus4 ();
  llpm_select_rr_if #(.WIDTH(8), .NUM_INPUTS(3), .CLOG2_NUM_INPUTS(2)) bus3 ();

  llpm_select_rr #(.WIDTH(8), .NUM_INPUTS(4), .CLOG2_NUM_INPUTS(2)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4));
  llpm_select_rr #(.WIDTH(8), .NUM_INPUTS(3), .CLOG2_NUM_INPUTS(2)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3));

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       rst;
    logic [3:0] v;
    logic [3:0] last;
    logic       abp;
    logic [3:0] ebp;
    logic       eav;
    logic [7:0] ea;
    logic [1:0] esel;
    logic       elast;
  } vec_t;

  vec_t tbl  [18];
  vec_t ltbl [11];

  // Reference model state, index 0 = 4-input instance, 1 = 3-input instance.
  int         m_n [2] = '{4, 3};
  bit         m_av [2];
  logic [7:0] m_a [2];
  int         m_sel [2];
  int         m_lg [2];
  bit         m_locked [2];
  int         m_lockch [2];
  bit         m_alast [2];

  // Grant = eligible valid channel closest (cyclically) after last grant.
  task automatic model_step(input int k, input logic rst, input logic [3:0] v,
                            input logic [3:0] last, input logic abp,
                            input logic [31:0] x, output logic [3:0] ebp);
    int n, best, g, d;
    bit has, load, elig;
    n = m_n[k]; best = n; g = 0; has = 0;
    for (int i = 0; i < n; i++) begin
      elig = v[i] && (!m_locked[k] || i == m_lockch[k]);
      d = (i - m_lg[k] - 1 + 2*n) % n;
      if (elig && d < best) begin best = d; g = i; has = 1; end
    end
    load = !m_av[k] || !abp;
    ebp  = 4'((1 << n) - 1);
    if (!rst && load && has) ebp[g] = 1'b0;
    if (rst) begin
      m_av[k] = 0; m_a[k] = 8'h00; m_sel[k] = 0; m_lg[k] = n - 1;
      m_locked[k] = 0; m_lockch[k] = 0; m_alast[k] = 0;
    end else if (load) begin
      if (has) begin
        m_a[k] = x[g*8 +: 8]; m_sel[k] = g; m_av[k] = 1; m_lg[k] = g;
        m_alast[k] = last[g];
`ifdef LLPM_SELECT_RR_LOCK_EN
        m_locked[k] = !last[g];
        m_lockch[k] = g;
`endif
      end else begin
        m_av[k] = 0;
      end
    end
  endtask

  task automatic run_row(input vec_t r, input string tag);
    reset        = r.rst;
    bus4.x       = {8'h13, 8'h12, 8'h11, 8'h10};
    bus4.x_valid = r.v;
    bus4.a_bp    = r.abp;
`ifdef LLPM_SELECT_RR_LOCK_EN
    bus4.x_last  = r.last;
`endif
    #1;
    chk({tag, "_bp"}, 32'(bus4.x_bp), 32'(r.ebp));
    @(posedge clk); #1;
    chk({tag, "_av"},  32'(bus4.a_valid), 32'(r.eav));
    chk({tag, "_a"},   32'(bus4.a), 32'(r.ea));
    chk({tag, "_sel"}, 32'(bus4.a_sel), 32'(r.esel));
`ifdef LLPM_SELECT_RR_LOCK_EN
    chk({tag, "_last"}, 32'(bus4.a_last), 32'(r.elast));
`endif
  endtask

  logic [3:0]  rv [2];
  logic [3:0]  rl [2];
  logic        rb [2];
  logic [31:0] rx [2];
  logic [3:0]  ebp [2];
  logic        rrst;

  initial begin
    // rst, v, last, abp | bp, av, a, sel, last   (x[i] = 8'h10+i)
    tbl[0]  = {1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[1]  = {1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[2]  = {1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 8'h10, 2'd0, 1'b1};
    tbl[3]  = {1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1101, 1'b1, 8'h11, 2'd1, 1'b1};
    tbl[4]  = {1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 8'h11, 2'd1, 1'b1};
    tbl[5]  = {1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 8'h11, 2'd1, 1'b1};
    tbl[6]  = {1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 8'h11, 2'd1, 1'b1};
    tbl[7]  = {1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1011, 1'b1, 8'h12, 2'd2, 1'b1};
    tbl[8]  = {1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0111, 1'b1, 8'h13, 2'd3, 1'b1};
    tbl[9]  = {1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 8'h10, 2'd0, 1'b1};
    tbl[10] = {1'b0, 4'b0100, 4'b1111, 1'b0, 4'b1011, 1'b1, 8'h12, 2'd2, 1'b1};
    tbl[11] = {1'b0, 4'b0010, 4'b1111, 1'b0, 4'b1101, 1'b1, 8'h11, 2'd1, 1'b1};
    tbl[12] = {1'b0, 4'b0000, 4'b1111, 1'b0, 4'b1111, 1'b0, 8'h11, 2'd1, 1'b1};
    tbl[13] = {1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1011, 1'b1, 8'h12, 2'd2, 1'b1};
    tbl[14] = {1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 8'h12, 2'd2, 1'b1};
    tbl[15] = {1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[16] = {1'b0, 4'b1000, 4'b1111, 1'b1, 4'b0111, 1'b1, 8'h13, 2'd3, 1'b1};
    tbl[17] = {1'b0, 4'b0001, 4'b1111, 1'b1, 4'b1111, 1'b1, 8'h13, 2'd3, 1'b1};

    ltbl[0]  = {1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0};
    ltbl[1]  = {1'b0, 4'b0010, 4'b1111, 1'b0, 4'b1101, 1'b1, 8'h11, 2'd1, 1'b1};
    ltbl[2]  = {1'b0, 4'b1111, 4'b1011, 1'b0, 4'b1011, 1'b1, 8'h12, 2'd2, 1'b0};
    ltbl[3]  = {1'b0, 4'b1111, 4'b1011, 1'b0, 4'b1011, 1'b1, 8'h12, 2'd2, 1'b0};
    ltbl[4]  = {1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1011, 1'b1, 8'h12, 2'd2, 1'b1};
    ltbl[5]  = {1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0111, 1'b1, 8'h13, 2'd3, 1'b1};
    ltbl[6]  = {1'b0, 4'b1111, 4'b1110, 1'b0, 4'b1110, 1'b1, 8'h10, 2'd0, 1'b0};
    ltbl[7]  = {1'b0, 4'b1110, 4'b1111, 1'b0, 4'b1111, 1'b0, 8'h10, 2'd0, 1'b0};
    ltbl[8]  = {1'b0, 4'b1110, 4'b1111, 1'b0, 4'b1111, 1'b0, 8'h10, 2'd0, 1'b0};
    ltbl[9]  = {1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 8'h10, 2'd0, 1'b1};
    ltbl[10] = {1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1101, 1'b1, 8'h11, 2'd1, 1'b1};

    bus3.x = '0; bus3.x_valid = '0; bus3.a_bp = 1'b0;
`ifdef LLPM_SELECT_RR_LOCK_EN
    bus3.x_last = '1;
`endif
    for (int i = 0; i < 18; i++) run_row(tbl[i], $sformatf("tbl%0d", i));
`ifdef LLPM_SELECT_RR_LOCK_EN
    for (int i = 0; i < 11; i++) run_row(ltbl[i], $sformatf("lock%0d", i));
`endif

    // 3-input instance: all valid must rotate 0,1,2,0 and never yield index 3.
    bus4.x_valid = '0; bus4.a_bp = 1'b0;
    bus3.x = {8'h22, 8'h21, 8'h20}; bus3.x_valid = 3'b111; bus3.a_bp = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("n3_%0d_bp", i), 32'(bus3.x_bp), 32'(~(3'b001 << (i % 3)) & 3'b111));
      @(posedge clk); #1;
      chk($sformatf("n3_%0d_sel", i), 32'(bus3.a_sel), 32'(i % 3));
      chk($sformatf("n3_%0d_a", i), 32'(bus3.a), 32'(8'h20 + (i % 3)));
    end

    // Randomized run on both instances against the reference model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rrst = (cyc == 0) || ($urandom_range(0, 63) == 0);
      for (int k = 0; k < 2; k++) begin
        rv[k] = 4'($urandom) & 4'((1 << m_n[k]) - 1);
        rl[k] = 4'($urandom);
        rb[k] = ($urandom_range(0, 3) == 0);
        rx[k] = $urandom;
        if (k == 1) rx[k][31:24] = 8'h00;
        model_step(k, rrst, rv[k], rl[k], rb[k], rx[k], ebp[k]);
      end
      reset        = rrst;
      bus4.x       = rx[0];       bus3.x       = rx[1][23:0];
      bus4.x_valid = rv[0];       bus3.x_valid = rv[1][2:0];
      bus4.a_bp    = rb[0];       bus3.a_bp    = rb[1];
`ifdef LLPM_SELECT_RR_LOCK_EN
      bus4.x_last  = rl[0];       bus3.x_last  = rl[1][2:0];
`endif
      #1;
      chk($sformatf("rnd%0d_bp4", cyc), 32'(bus4.x_bp), 32'(ebp[0]));
      chk($sformatf("rnd%0d_bp3", cyc), 32'(bus3.x_bp), 32'(ebp[1]));
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_av4", cyc),  32'(bus4.a_valid), 32'(m_av[0]));
      chk($sformatf("rnd%0d_a4", cyc),   32'(bus4.a), 32'(m_a[0]));
      chk($sformatf("rnd%0d_sel4", cyc), 32'(bus4.a_sel), 32'(m_sel[0]));
      chk($sformatf("rnd%0d_av3", cyc),  32'(bus3.a_valid), 32'(m_av[1]));
      chk($sformatf("rnd%0d_a3", cyc),   32'(bus3.a), 32'(m_a[1]));
      chk($sformatf("rnd%0d_sel3", cyc), 32'(bus3.a_sel), 32'(m_sel[1]));
`ifdef LLPM_SELECT_RR_LOCK_EN
      chk($sformatf("rnd%0d_last4", cyc), 32'(bus4.a_last), 32'(m_alast[0]));
      chk($sformatf("rnd%0d_last3", cyc), 32'(bus3.a_last), 32'(m_alast[1]));
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
